// File: rtl/alu_arb_pkg.sv
// ============================================================================
// Module : alu_arb_pkg
// Shared widths, control-bit indices, FSM encoding and the Hack ALU function.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_arb_pkg;

  localparam int ALU_W  = 16;
  localparam int CTRL_W = 6;

  localparam int ZX = 5;
  localparam int NX = 4;
  localparam int ZY = 3;
  localparam int NY = 2;
  localparam int F  = 1;
  localparam int NO = 0;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Stateless 16-bit Hack ALU; the adder carry-out is dropped.
  function automatic logic [ALU_W-1:0] alu_eval(
    input logic [ALU_W-1:0]  x,
    input logic [ALU_W-1:0]  y,
    input logic [CTRL_W-1:0] c
  );
    logic [ALU_W-1:0] xa;
    logic [ALU_W-1:0] ya;
    logic [ALU_W-1:0] r;
    xa = c[ZX] ? '0 : x;
    xa = c[NX] ? ~xa : xa;
    ya = c[ZY] ? '0 : y;
    ya = c[NY] ? ~ya : ya;
    r  = c[F] ? (xa + ya) : (xa & ya);
    return c[NO] ? ~r : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_arb_grant.sv
// ============================================================================
// Module : alu_arb_grant
// Combinational grant picker: round-robin from last grant + 1, or lowest index.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_arb_grant #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 2,
  parameter bit RR_EN = 1'b0
) (
  input  logic [N_REQ-1:0] i_req_valid,
  input  logic [ID_W-1:0]  i_last_grant,
  output logic             o_gnt_valid,
  output logic [ID_W-1:0]  o_gnt_idx
);

  int w_start;

  // Walk candidates from farthest to nearest so the nearest valid one wins.
  always_comb begin
    o_gnt_valid = 1'b0;
    o_gnt_idx   = '0;
    w_start     = RR_EN ? ((int'(i_last_grant) + 1) % N_REQ) : 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (i_req_valid[j] && (j == ((w_start + k) % N_REQ))) begin
          o_gnt_valid = 1'b1;
          o_gnt_idx   = ID_W'(j);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_share_arb.sv
// ============================================================================
// Module : alu_share_arb
// One Hack ALU shared by N_REQ requesters with a single-entry result register.
// Define ALU_ARB_RR_EN for round-robin; otherwise fixed priority (index 0 first).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_share_arb
  import alu_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*ALU_W-1:0]  req_x,
  input  logic [N_REQ*ALU_W-1:0]  req_y,
  input  logic [N_REQ*CTRL_W-1:0] req_ctrl,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ALU_W-1:0]        rsp_out,
  output logic                    rsp_zr,
  output logic                    rsp_ng,
  output logic [ID_W-1:0]         rsp_id
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_can_accept;
  logic               w_accept;
  logic               w_gnt_valid;
  logic [ID_W-1:0]    w_gnt;
  logic [ID_W-1:0]    w_last;
  logic [ALU_W-1:0]   w_sel_x;
  logic [ALU_W-1:0]   w_sel_y;
  logic [CTRL_W-1:0]  w_sel_ctrl;
  logic [ALU_W-1:0]   w_alu;
  logic [ALU_W-1:0]   r_out;
  logic               r_zr;
  logic               r_ng;
  logic [ID_W-1:0]    r_id;

`ifdef ALU_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
  logic [ID_W-1:0] r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= '0;
    end else if (w_accept) begin
      r_last <= w_gnt;
    end
  end

  assign w_last = r_last;
`else
  localparam bit RR_EN = 1'b0;
  assign w_last = '0;
`endif

  alu_arb_grant #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W),
    .RR_EN (RR_EN)
  ) u_grant (
    .i_req_valid  (req_valid),
    .i_last_grant (w_last),
    .o_gnt_valid  (w_gnt_valid),
    .o_gnt_idx    (w_gnt)
  );

  assign w_can_accept = (r_state == EMPTY) || ((r_state == FULL) && rsp_ready);
  assign w_accept     = w_can_accept && w_gnt_valid;

  always_comb begin
    w_sel_x    = '0;
    w_sel_y    = '0;
    w_sel_ctrl = '0;
    req_ready  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt == ID_W'(i)) begin
        w_sel_x      = req_x[i*ALU_W +: ALU_W];
        w_sel_y      = req_y[i*ALU_W +: ALU_W];
        w_sel_ctrl   = req_ctrl[i*CTRL_W +: CTRL_W];
        req_ready[i] = w_accept;
      end
    end
  end

  assign w_alu = alu_eval(w_sel_x, w_sel_y, w_sel_ctrl);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_accept) w_state_nxt = FULL;
      FULL:    if (rsp_ready && !w_accept) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Flags are captured with the result so they read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
      r_zr  <= 1'b0;
      r_ng  <= 1'b0;
      r_id  <= '0;
    end else if (w_accept) begin
      r_out <= w_alu;
      r_zr  <= (w_alu == '0);
      r_ng  <= w_alu[ALU_W-1];
      r_id  <= w_gnt;
    end
  end

  assign rsp_valid = (r_state == FULL);
  assign rsp_out   = r_out;
  assign rsp_zr    = r_zr;
  assign rsp_ng    = r_ng;
  assign rsp_id    = r_id;

endmodule

`default_nettype wire
